// File: rtl/muladd_mac_pipe.sv
// muladd_mac_pipe: two-stage pipelined multiply-add / accumulate engine.
// Build option MULADD_MAC_SAT_EN: clamp q/acc on overflow instead of wrapping.
module muladd_mac_pipe #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int ACC_W  = 20,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_mode,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [ACC_W-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] q,
    output logic             ovf
);

    localparam int PW = A_W + B_W;
    localparam int SW = ACC_W + 1;

    logic             r_s1_valid;
    logic [PW-1:0]    r_s1_p;
    logic [ACC_W-1:0] r_s1_c;
    logic             r_s1_mode;
    logic [ACC_W-1:0] r_q;
    logic             r_out_valid;
    logic             r_ovf;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [SW-1:0]    w_p_ext;
    logic [ACC_W-1:0] w_base;
    logic [SW-1:0]    w_base_ext;
    logic [SW-1:0]    w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_res;
    logic             w_advance;
    logic             w_s2_load;
    logic             w_accept;

    // Low PW bits of the product are the same for signed and unsigned
    // once both operands are extended to PW bits.
    assign w_a_ext = {{B_W{SIGNED & a[A_W-1]}}, a};
    assign w_b_ext = {{A_W{SIGNED & b[B_W-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // One guard bit above ACC_W is enough to see any overflow of p + base.
    assign w_p_ext    = {{(SW-PW){SIGNED & r_s1_p[PW-1]}}, r_s1_p};
    assign w_base     = r_s1_mode ? r_q : r_s1_c;
    assign w_base_ext = {SIGNED & w_base[ACC_W-1], w_base};
    assign w_sum      = w_p_ext + w_base_ext;
    assign w_ovf      = SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1])
                               : w_sum[ACC_W];

`ifdef MULADD_MAC_SAT_EN
    logic [ACC_W-1:0] w_max;
    logic [ACC_W-1:0] w_min;

    assign w_max = SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    assign w_min = SIGNED ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};
    // Guard bit is the true sign of the sum when operands are signed.
    assign w_res = !w_ovf ? w_sum[ACC_W-1:0]
                 : (SIGNED & w_sum[ACC_W]) ? w_min : w_max;
`else
    assign w_res = w_sum[ACC_W-1:0];
`endif

    assign w_advance = !r_out_valid | out_ready;
    assign w_s2_load = w_advance & r_s1_valid;
    assign in_ready  = rst_n & !clr & (!r_s1_valid | w_advance);
    assign w_accept  = in_valid & in_ready;

    assign q         = r_q;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

    // Stage 1: capture product, addend and mode of an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_c     <= '0;
            r_s1_mode  <= 1'b0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_p    <= w_prod;
                r_s1_c    <= c;
                r_s1_mode <= acc_mode;
            end
        end
    end

    // Stage 2: add, register result (q doubles as accumulator), sticky ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clr) begin
            r_q         <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_load) begin
            r_q         <= w_res;
            r_out_valid <= 1'b1;
            r_ovf       <= r_ovf | w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muladd_mac_pipe.sv
// tb_muladd_mac_pipe: directed vector bench for muladd_mac_pipe.
// Drives one unsigned and one signed instance from shared stimulus.
module tb_muladd_mac_pipe;

`ifdef MULADD_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        acc_mode;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] c;

    logic        in_ready_u, out_valid_u, ovf_u;
    logic        in_ready_s, out_valid_s, ovf_s;
    logic [19:0] q_u, q_s;

    logic        cur_sgn;
    logic        in_ready, out_valid, ovf;
    logic [19:0] q;

    assign in_ready  = cur_sgn ? in_ready_s  : in_ready_u;
    assign out_valid = cur_sgn ? out_valid_s : out_valid_u;
    assign ovf       = cur_sgn ? ovf_s       : ovf_u;
    assign q         = cur_sgn ? q_s         : q_u;

    muladd_mac_pipe #(.A_W(8), .B_W(8), .ACC_W(20), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_u), .acc_mode(acc_mode),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .q(q_u), .ovf(ovf_u)
    );

    muladd_mac_pipe #(.A_W(8), .B_W(8), .ACC_W(20), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_s), .acc_mode(acc_mode),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .q(q_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [19:0] c;
        logic [19:0] q;
        logic        ovf;
    } vec_t;

    vec_t tv[9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] bp_exp[5];
        logic [19:0] hold_q;
        logic        hold_v;
        int          idx, got, stalls;

        tv[0] = '{1'b0, 8'd200, 8'd100, 20'd5,      20'h04E25, 1'b0};
        tv[1] = '{1'b1, 8'hFD,  8'd7,   20'd10,     20'hFFFF5, 1'b0};
        tv[2] = '{1'b1, 8'h80,  8'h80,  20'd0,      20'h04000, 1'b0};
        tv[3] = '{1'b0, 8'hFF,  8'hFF,  20'd0,      20'h0FE01, 1'b0};
        tv[4] = '{1'b1, 8'h01,  8'hFF,  20'd1,      20'h00000, 1'b0};
        tv[5] = '{1'b1, 8'h00,  8'h55,  20'h80000,  20'h80000, 1'b0};
        tv[6] = '{1'b0, 8'hFF,  8'hFF,  20'hFFFFF,
                  SAT ? 20'hFFFFF : 20'h0FE00, 1'b1};
        tv[7] = '{1'b1, 8'h7F,  8'h7F,  20'h7FFFF,
                  SAT ? 20'h7FFFF : 20'h83F00, 1'b1};
        tv[8] = '{1'b1, 8'h80,  8'h7F,  20'h80000,
                  SAT ? 20'h80000 : 20'h7C080, 1'b1};
        bp_exp[0] = 20'd3;
        bp_exp[1] = 20'd7;
        bp_exp[2] = 20'd11;
        bp_exp[3] = 20'd15;
        bp_exp[4] = 20'd19;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; acc_mode = 1'b0;
        out_ready = 1'b1; a = '0; b = '0; c = '0; cur_sgn = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Single-shot table
        for (int i = 0; i < 9; i++) begin
            cur_sgn = tv[i].sgn;
            pulse_clr();
            in_valid = 1'b1; acc_mode = 1'b0;
            a = tv[i].a; b = tv[i].b; c = tv[i].c;
            #1;
            chk($sformatf("tv%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("tv%0d_lat_ov", i), out_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("tv%0d_ov", i), out_valid, 1);
            chk($sformatf("tv%0d_q", i), q, tv[i].q);
            chk($sformatf("tv%0d_ovf", i), ovf, tv[i].ovf);
        end

        // Accumulate chain, back-to-back
        cur_sgn = 1'b1;
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; a = 8'd100; b = 8'd100; c = 20'd0;
                acc_mode = (i != 0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                chk($sformatf("acc%0d_ov", i), out_valid, 1);
                chk($sformatf("acc%0d_q", i), q, 32'(10000 * i));
            end
        end
        in_valid = 1'b0; acc_mode = 1'b0;

        // Back-pressure mid-stream
        cur_sgn = 1'b0;
        pulse_clr();
        idx = 0; got = 0; stalls = 0; hold_v = 1'b0; hold_q = '0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (idx < 5) begin
                in_valid = 1'b1; a = 8'(idx + 1); b = 8'd3; c = 20'(idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold_v) chk("bp_hold_q", q, hold_q);
            if (in_valid && !in_ready) stalls++;
            if (out_valid && out_ready) begin
                if (got < 5) chk($sformatf("bp_q%0d", got), q, bp_exp[got]);
                got++;
            end
            hold_v = out_valid & !out_ready;
            hold_q = q;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", got, 5);
        chk("bp_stalled", stalls > 0, 1);
        chk("bp_drained", out_valid, 0);

        // Signed overflow through 32-beat accumulation
        cur_sgn = 1'b1;
        pulse_clr();
        for (int i = 0; i < 34; i++) begin
            if (i < 32) begin
                in_valid = 1'b1; a = 8'h80; b = 8'h80; c = 20'd0;
                acc_mode = (i != 0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i == 1) chk("ovfseq_q1", q, 20'h04000);
            if (i == 31) begin
                chk("ovfseq_q31", q, 20'h7C000);
                chk("ovfseq_ovf31", ovf, 0);
            end
            if (i == 32) begin
                chk("ovfseq_q32", q, SAT ? 20'h7FFFF : 20'h80000);
                chk("ovfseq_ovf32", ovf, 1);
            end
        end
        acc_mode = 1'b0;
        clr = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1; c = 20'd1;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_ovf", ovf, 0);
        chk("clr_q", q, 0);
        chk("clr_ov", out_valid, 0);
        @(posedge clk); #1;
        chk("clr_no_accept", out_valid, 0);

        // Async reset with S2 stalled and S1 full
        cur_sgn = 1'b0;
        pulse_clr();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; c = 20'hFFFFF;
        @(posedge clk); #1;
        a = 8'd200; b = 8'd100; c = 20'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_ov", out_valid, 1);
        chk("pre_rst_ovf", ovf, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", q, 0);
        chk("arst_ov", out_valid, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_arst_ov", out_valid, 0);
        in_valid = 1'b1; a = 8'd200; b = 8'd100; c = 20'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_arst_res_ov", out_valid, 1);
        chk("post_arst_res_q", q, 20'h04E25);
        chk("post_arst_res_ovf", ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
